// File: rtl/isp_wr_arbiter.sv
// Two-channel round-robin burst write arbiter feeding the SDRAM controller write port.
// Generates linear frame-buffer addresses per channel and flags end-of-frame.
module isp_wr_arbiter #(
  parameter int                DATA_W      = 16,
  parameter int                ADDR_W      = 24,
  parameter int                BURST_LEN   = 64,
  parameter int                FRAME_WORDS = 2106368,
  parameter logic [ADDR_W-1:0] CH0_BASE    = 24'h000000,
  parameter logic [ADDR_W-1:0] CH1_BASE    = 24'h400000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              ch0_req,
  input  logic              ch1_req,
  input  logic [DATA_W-1:0] ch0_data,
  input  logic [DATA_W-1:0] ch1_data,
  output logic              ch0_rd,
  output logic              ch1_rd,
  output logic              ch0_frame_done,
  output logic              ch1_frame_done,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_ack,
  input  logic              wr_data_req,
  output logic [DATA_W-1:0] wr_data,
  input  logic              wr_done,
  output logic              busy
);

  localparam int                CNT_W     = $clog2(BURST_LEN) + 1;
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BURST_LEN - 1);
  localparam logic [ADDR_W-1:0] BURST_INC = ADDR_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0] FRAME_END = ADDR_W'(FRAME_WORDS);

  typedef enum logic [1:0] {IDLE, CMD, DATA, WAIT_DONE} state_t;

  state_t            state;
  logic              cur_ch;
  logic              last_grant;
  logic              fs_pending;
  logic [ADDR_W-1:0] ptr0;
  logic [ADDR_W-1:0] ptr1;
  logic [CNT_W-1:0]  cnt;

  logic              any_req;
  logic              grant_ch;
  logic [ADDR_W-1:0] grant_addr;
  logic              data_take;
  logic [ADDR_W-1:0] next_ptr;

  // A tie goes to the channel that did not win last; a lone requester always wins.
  assign any_req    = ch0_req | ch1_req;
  assign grant_ch   = (ch0_req & ch1_req) ? ~last_grant : ch1_req;
  assign grant_addr = grant_ch ? (CH1_BASE + (frame_start ? '0 : ptr1))
                               : (CH0_BASE + (frame_start ? '0 : ptr0));

  // Pulls past the burst length are ignored so the FIFO never over-pops.
  assign data_take = (state == DATA) & wr_data_req & (cnt < CNT_FULL);
  assign ch0_rd    = data_take & ~cur_ch;
  assign ch1_rd    = data_take & cur_ch;
  assign wr_data   = cur_ch ? ch1_data : ch0_data;
  assign next_ptr  = (cur_ch ? ptr1 : ptr0) + BURST_INC;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cur_ch         <= 1'b0;
      last_grant     <= 1'b1;
      fs_pending     <= 1'b0;
      ptr0           <= '0;
      ptr1           <= '0;
      cnt            <= '0;
      wr_req         <= 1'b0;
      wr_addr        <= '0;
      busy           <= 1'b0;
      ch0_frame_done <= 1'b0;
      ch1_frame_done <= 1'b0;
    end else begin
      ch0_frame_done <= 1'b0;
      ch1_frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_start) begin
            ptr0 <= '0;
            ptr1 <= '0;
          end
          if (any_req) begin
            cur_ch  <= grant_ch;
            wr_addr <= grant_addr;
            wr_req  <= 1'b1;
            busy    <= 1'b1;
            state   <= CMD;
          end
        end
        CMD: begin
          if (frame_start) fs_pending <= 1'b1;
          if (wr_ack) begin
            wr_req     <= 1'b0;
            cnt        <= '0;
            last_grant <= cur_ch;
            state      <= DATA;
          end
        end
        DATA: begin
          if (frame_start) fs_pending <= 1'b1;
          if (data_take) cnt <= cnt + 1'b1;
          if ((data_take && cnt == CNT_LAST) || cnt == CNT_FULL) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (wr_done) begin
            if (next_ptr == FRAME_END) begin
              if (cur_ch) begin
                ptr1           <= '0;
                ch1_frame_done <= 1'b1;
              end else begin
                ptr0           <= '0;
                ch0_frame_done <= 1'b1;
              end
            end else if (cur_ch) begin
              ptr1 <= next_ptr;
            end else begin
              ptr0 <= next_ptr;
            end
            // A frame restart requested during the burst wins over its pointer update.
            if (frame_start || fs_pending) begin
              ptr0 <= '0;
              ptr1 <= '0;
            end
            fs_pending <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end else if (frame_start) begin
            fs_pending <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_isp_wr_arbiter.sv
// Directed bench for isp_wr_arbiter: burst vector table plus frame_start and async reset sequences.
// FRAME_WORDS is shrunk to 256 so frame wrap shows up after four bursts per channel.
module tb_isp_wr_arbiter;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 24;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              frame_start = 1'b0;
  logic              ch0_req = 1'b0;
  logic              ch1_req = 1'b0;
  logic [DATA_W-1:0] ch0_data;
  logic [DATA_W-1:0] ch1_data;
  logic              ch0_rd;
  logic              ch1_rd;
  logic              ch0_frame_done;
  logic              ch1_frame_done;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_ack = 1'b0;
  logic              wr_data_req = 1'b0;
  logic [DATA_W-1:0] wr_data;
  logic              wr_done = 1'b0;
  logic              busy;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] head0 = 16'h1000;
  logic [DATA_W-1:0] head1 = 16'h2000;
  logic [DATA_W-1:0] expw [2];

  typedef struct {
    logic              req0;
    logic              req1;
    logic              gapped;
    int                extra;
    logic              fs;
    logic              exp_ch;
    logic [ADDR_W-1:0] exp_addr;
    logic              exp_fd;
  } vec_t;

  vec_t tbl [12];

  isp_wr_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_LEN(64), .FRAME_WORDS(256),
    .CH0_BASE(24'h000000), .CH1_BASE(24'h400000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .ch0_req(ch0_req), .ch1_req(ch1_req), .ch0_data(ch0_data), .ch1_data(ch1_data),
    .ch0_rd(ch0_rd), .ch1_rd(ch1_rd),
    .ch0_frame_done(ch0_frame_done), .ch1_frame_done(ch1_frame_done),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_ack(wr_ack), .wr_data_req(wr_data_req),
    .wr_data(wr_data), .wr_done(wr_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Show-ahead FIFO heads: each pop exposes the next word of a counting sequence.
  assign ch0_data = head0;
  assign ch1_data = head1;
  always @(posedge clk) begin
    if (ch0_rd) head0 <= head0 + 16'd1;
    if (ch1_rd) head1 <= head1 + 16'd1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // One full burst: command, ack, data pulls, optional extra pulls, wr_done, frame_done cycle.
  task automatic applyStimulus(input vec_t v);
    logic got;
    logic tog;
    logic rd_ok;
    logic rd_bad;
    int   pops;
    ch0_req = v.req0;
    ch1_req = v.req1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      #1;
      if (i == 0) begin
        checkOutput("fd0_single", 32'(ch0_frame_done), 32'd0);
        checkOutput("fd1_single", 32'(ch1_frame_done), 32'd0);
        checkOutput("req_latency", 32'(wr_req), 32'd1);
      end
      if (wr_req) got = 1'b1;
    end
    if (!got) begin
      checkOutput("wr_req_timeout", 32'd0, 32'd1);
      return;
    end
    checkOutput("wr_addr", 32'(wr_addr), 32'(v.exp_addr));
    checkOutput("busy_cmd", 32'(busy), 32'd1);
    @(negedge clk);
    wr_ack = 1'b1;
    #1;
    checkOutput("wr_req_hold", 32'(wr_req), 32'd1);
    pops = 0;
    tog = 1'b1;
    for (int cyc = 0; cyc < 300 && pops < 64; cyc++) begin
      @(negedge clk);
      wr_ack = 1'b0;
      wr_data_req = v.gapped ? tog : 1'b1;
      tog = ~tog;
      frame_start = v.fs && (cyc == 10);
      #1;
      if (cyc == 0) checkOutput("wr_req_drop", 32'(wr_req), 32'd0);
      rd_ok  = v.exp_ch ? ch1_rd : ch0_rd;
      rd_bad = v.exp_ch ? ch0_rd : ch1_rd;
      if (rd_bad) checkOutput("wrong_ch_rd", 32'(rd_bad), 32'd0);
      checkOutput("rd_follow", 32'(rd_ok), 32'(wr_data_req));
      if (rd_ok) begin
        checkOutput("wr_data", 32'(wr_data), 32'(expw[v.exp_ch]));
        expw[v.exp_ch] = expw[v.exp_ch] + 16'd1;
        pops++;
      end
    end
    checkOutput("pop_count", 32'(pops), 32'd64);
    for (int e = 0; e < v.extra; e++) begin
      @(negedge clk);
      wr_data_req = 1'b1;
      frame_start = 1'b0;
      #1;
      checkOutput("extra_rd0", 32'(ch0_rd), 32'd0);
      checkOutput("extra_rd1", 32'(ch1_rd), 32'd0);
      checkOutput("extra_data_hold", 32'(wr_data), 32'(expw[v.exp_ch]));
      checkOutput("busy_wait", 32'(busy), 32'd1);
    end
    @(negedge clk);
    wr_data_req = 1'b0;
    frame_start = 1'b0;
    wr_done = 1'b1;
    #1;
    checkOutput("busy_done", 32'(busy), 32'd1);
    checkOutput("wr_req_done", 32'(wr_req), 32'd0);
    @(negedge clk);
    wr_done = 1'b0;
    #1;
    checkOutput("fd0", 32'(ch0_frame_done), 32'(v.exp_fd && !v.exp_ch));
    checkOutput("fd1", 32'(ch1_frame_done), 32'(v.exp_fd && v.exp_ch));
    checkOutput("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    expw[0] = 16'h1000;
    expw[1] = 16'h2000;
    //            req0  req1  gap  extra fs    ch    addr          fd
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 24'h000000, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 24'h000040, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 3, 1'b0, 1'b0, 24'h000080, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 24'h0000C0, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 24'h000000, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b1, 24'h400000, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 24'h000040, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b1, 24'h400040, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1, 24'h400080, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 24'h000080, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b1, 24'h4000C0, 1'b1};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 24'h0000C0, 1'b1};

    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_wr_req", 32'(wr_req), 32'd0);
    checkOutput("rst_wr_addr", 32'(wr_addr), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_fd", 32'({ch0_frame_done, ch1_frame_done}), 32'd0);
    checkOutput("rst_rd", 32'({ch0_rd, ch1_rd}), 32'd0);
    rst_n = 1'b1;

    for (int n = 0; n < 12; n++) applyStimulus(tbl[n]);

    // frame_start during DATA of the second ch0 burst rewinds both channels.
    applyStimulus('{1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1, 24'h400000, 1'b0});
    applyStimulus('{1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 24'h000000, 1'b0});
    applyStimulus('{1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, 24'h000040, 1'b0});
    applyStimulus('{1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b1, 24'h400000, 1'b0});
    applyStimulus('{1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 24'h000000, 1'b0});

    // frame_start while idle.
    ch0_req = 1'b0;
    ch1_req = 1'b0;
    @(negedge clk);
    frame_start = 1'b1;
    #1;
    checkOutput("idle_busy", 32'(busy), 32'd0);
    @(negedge clk);
    frame_start = 1'b0;
    applyStimulus('{1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1, 24'h400000, 1'b0});
    applyStimulus('{1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 24'h000000, 1'b0});

    // Asynchronous reset in the middle of a ch0 burst.
    ch0_req = 1'b1;
    ch1_req = 1'b0;
    begin
      logic got;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk);
        #1;
        if (wr_req) got = 1'b1;
      end
      checkOutput("ar_wr_req_seen", 32'(got), 32'd1);
    end
    checkOutput("ar_wr_addr", 32'(wr_addr), 32'h000040);
    @(negedge clk);
    wr_ack = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      wr_ack = 1'b0;
      wr_data_req = 1'b1;
      #1;
      checkOutput("ar_pre_rd", 32'(ch0_rd), 32'd1);
      if (ch0_rd) begin
        checkOutput("ar_pre_data", 32'(wr_data), 32'(expw[0]));
        expw[0] = expw[0] + 16'd1;
      end
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("ar_wr_req", 32'(wr_req), 32'd0);
    checkOutput("ar_wr_addr_clr", 32'(wr_addr), 32'd0);
    checkOutput("ar_busy", 32'(busy), 32'd0);
    checkOutput("ar_rd", 32'({ch0_rd, ch1_rd}), 32'd0);
    checkOutput("ar_fd", 32'({ch0_frame_done, ch1_frame_done}), 32'd0);
    wr_data_req = 1'b0;
    ch0_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus('{1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 24'h000000, 1'b0});

    ch0_req = 1'b0;
    ch1_req = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("end_busy", 32'(busy), 32'd0);
    checkOutput("end_wr_req", 32'(wr_req), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
